// File: rtl/cdc_sync_filter.sv
// cdc_sync_filter: multi-channel asynchronous-input synchronizer with a
// per-channel glitch filter and registered rise/fall/changed event pulses.
// All logic runs on out_clk; each channel is fully independent.
module cdc_sync_filter #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      STAGES        = 2,
    parameter int unsigned      FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             out_clk,
    input  logic             out_reset_n,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall,
    output logic             out_changed
);

    localparam int unsigned CNT_W = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    // Reject illegal configurations at elaboration
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("cdc_sync_filter: STAGES must be in 2..4");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("cdc_sync_filter: FILTER_CYCLES must be >= 1");
    end

    (* preserve = "true", dont_replicate = "true" *)
    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_w;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic             changed_d;

    // Plain flop chain; nothing may sit between stages
    always_ff @(posedge out_clk or negedge out_reset_n) begin
        if (!out_reset_n) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                sync_q[s] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= in_data;
            for (int s = 1; s < int'(STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_w = sync_q[STAGES-1];

    // Filter next state: count consecutive mismatching samples, commit at threshold
    always_comb begin
        data_d = out_data;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync_w[i] == out_data[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                data_d[i] = sync_w[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync_w[i];
                fall_d[i] = ~sync_w[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    // Filter state and registered outputs
    always_ff @(posedge out_clk or negedge out_reset_n) begin
        if (!out_reset_n) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
            out_data    <= RESET_VAL;
            out_rise    <= '0;
            out_fall    <= '0;
            out_changed <= 1'b0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_data    <= data_d;
            out_rise    <= rise_d;
            out_fall    <= fall_d;
            out_changed <= changed_d;
        end
    end

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Directed bench for cdc_sync_filter: default build plus a STAGES=3,
// FILTER_CYCLES=1 build sharing clock and reset.
module tb_cdc_sync_filter;

    logic       out_clk;
    logic       out_reset_n;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic [7:0] out_rise;
    logic [7:0] out_fall;
    logic       out_changed;

    logic [7:0] in_alt;
    logic [7:0] data_alt;
    logic [7:0] rise_alt;
    logic [7:0] fall_alt;
    logic       changed_alt;

    int checks = 0;
    int errors = 0;

    cdc_sync_filter dut (
        .out_clk     (out_clk),
        .out_reset_n (out_reset_n),
        .in_data     (in_data),
        .out_data    (out_data),
        .out_rise    (out_rise),
        .out_fall    (out_fall),
        .out_changed (out_changed)
    );

    cdc_sync_filter #(.STAGES(3), .FILTER_CYCLES(1)) dut_alt (
        .out_clk     (out_clk),
        .out_reset_n (out_reset_n),
        .in_data     (in_alt),
        .out_data    (data_alt),
        .out_rise    (rise_alt),
        .out_fall    (fall_alt),
        .out_changed (changed_alt)
    );

    initial out_clk = 1'b0;
    always #5 out_clk = ~out_clk;

    task automatic tick();
        @(posedge out_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] d, input logic [7:0] r,
                           input logic [7:0] f, input logic c);
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".rise"}, out_rise, r);
        chk({tag, ".fall"}, out_fall, f);
        chk({tag, ".changed"}, {7'd0, out_changed}, {7'd0, c});
    endtask

    initial begin
        // Reset and startup with in_data=0xFF
        out_reset_n = 1'b0;
        in_data     = 8'hFF;
        in_alt      = 8'h00;
        #2;
        chk_all("rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk_all("rst_hold2", 8'h00, 8'h00, 8'h00, 1'b0);
        out_reset_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_all("startup_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        tick();
        chk_all("startup_edge6", 8'hFF, 8'hFF, 8'h00, 1'b1);
        tick();
        chk_all("startup_edge7", 8'hFF, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset between edges clears outputs immediately
        out_reset_n = 1'b0;
        in_data     = 8'h00;
        #1;
        chk_all("async_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        out_reset_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk_all("idle_after_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        end

        // Glitch: bit0 high for 3 cycles
        in_data = 8'h01;
        tick(); tick(); tick();
        in_data = 8'h00;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk_all("glitch3", 8'h00, 8'h00, 8'h00, 1'b0);
        end

        // Glitch: 3 high, 1 low, 3 high
        in_data = 8'h01;
        tick(); tick(); tick();
        in_data = 8'h00;
        tick();
        in_data = 8'h01;
        tick(); tick(); tick();
        in_data = 8'h00;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk_all("glitch331", 8'h00, 8'h00, 8'h00, 1'b0);
        end

        // Threshold: bit0 high for exactly 4 cycles
        in_data = 8'h01;
        tick(); tick(); tick(); tick();
        in_data = 8'h00;
        tick();
        chk_all("thr_edge5", 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        chk_all("thr_rise_edge6", 8'h01, 8'h01, 8'h00, 1'b1);
        for (int e = 7; e <= 9; e++) begin
            tick();
            chk_all("thr_hold", 8'h01, 8'h00, 8'h00, 1'b0);
        end
        tick();
        chk_all("thr_fall_edge10", 8'h00, 8'h00, 8'h01, 1'b1);
        tick();
        chk_all("thr_after", 8'h00, 8'h00, 8'h00, 1'b0);

        // Independent channels: reach 0x20, then set bit3 and clear bit5
        in_data = 8'h20;
        for (int e = 0; e < 6; e++) tick();
        chk_all("ind_pre", 8'h20, 8'h20, 8'h00, 1'b1);
        tick();
        in_data = 8'h08;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_all("ind_wait", 8'h20, 8'h00, 8'h00, 1'b0);
        end
        tick();
        chk_all("ind_edge6", 8'h08, 8'h08, 8'h20, 1'b1);
        tick();
        chk_all("ind_after", 8'h08, 8'h00, 8'h00, 1'b0);

        // Reset mid-filter: bit2 (and bit3) counting at 2
        in_data = 8'h04;
        tick(); tick(); tick(); tick();
        chk_all("midf_pre", 8'h08, 8'h00, 8'h00, 1'b0);
        out_reset_n = 1'b0;
        #1;
        chk_all("midf_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        out_reset_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_all("midf_wait", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        tick();
        chk_all("midf_edge6", 8'h04, 8'h04, 8'h00, 1'b1);
        tick();
        chk_all("midf_after", 8'h04, 8'h00, 8'h00, 1'b0);

        // Alternate build: STAGES=3, FILTER_CYCLES=1, step on bit7
        chk("alt_idle", data_alt, 8'h00);
        in_alt = 8'h80;
        tick(); tick(); tick();
        chk("alt_edge3_data", data_alt, 8'h00);
        chk("alt_edge3_rise", rise_alt, 8'h00);
        tick();
        chk("alt_edge4_data", data_alt, 8'h80);
        chk("alt_edge4_rise", rise_alt, 8'h80);
        chk("alt_edge4_fall", fall_alt, 8'h00);
        chk("alt_edge4_chg", {7'd0, changed_alt}, 8'h01);
        tick();
        chk("alt_edge5_data", data_alt, 8'h80);
        chk("alt_edge5_rise", rise_alt, 8'h00);
        chk("alt_edge5_chg", {7'd0, changed_alt}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
